conv2d_input_unpacker: RTL and testbench
========================================

# conv2d_input_unpacker

Ingress counterpart of the conv2d output buffer. It accepts 128-bit packed pixel words (16 × 8-bit bytes) over a valid/ready stream and buffers them in a ring-buffer FIFO. It then unpacks each word into consecutive per-channel pixel vectors of `NUM_IN_CHANNELS` bytes for the conv2d core. Byte order mirrors the output packer: the lowest channel index sits in the most-significant byte.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO depth in 128-bit words; must be a power of two ≥ 2.
- `NUM_IN_CHANNELS`, default 4: bytes per output vector; legal values are 1, 2, 4, 8, 16.
- Derived `VPW` = 16 / `NUM_IN_CHANNELS`: vectors per word.

Ports:
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  128: packed pixel word.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the FIFO can accept a word this cycle.
- `out_px_vec`  out  [`NUM_IN_CHANNELS`-1:0][7:0]: unpacked pixel vector, registered.
- `out_valid`  out  1: `out_px_vec` is valid, registered.
- `out_ready`  in  1: the downstream core accepts the vector.
- `out_last`  out  1: the current vector is the final slice of its word (`sel` = `VPW`-1), registered.
- `fifo_count`  out  $clog2(`DEPTH`)+1: number of words currently stored, registered.

## Operation
- Storage: `fifo_mem[DEPTH]` of 128 bits, plus `wr_ptr` and `rd_ptr` of $clog2(`DEPTH`) bits, which wrap naturally. Also a count register and a slice counter `sel` in 0..`VPW`-1.
- Push:
  - `in_ready` = (count < `DEPTH`), combinational from the registered count.
  - When `in_valid && in_ready`, write `fifo_mem[wr_ptr]` and increment `wr_ptr`.
- Output register load condition, `load`: (count > 0) && (!`out_valid` || `out_ready`).
- On `load`:
  - For each channel i, `out_px_vec[i]` = `fifo_mem[rd_ptr]`[127 − (`sel`·N + i)·8 −: 8], where N = `NUM_IN_CHANNELS`.
  - `out_valid` ← 1.
  - `out_last` ← (`sel` == `VPW`-1).
  - If `sel` == `VPW`-1: `sel` ← 0, `rd_ptr` increments, and the word is popped. Otherwise `sel` increments.
- Consumption without reload: if `out_valid && out_ready && !load`, then `out_valid` ← 0. `out_px_vec` holds its last value.
- Stall: when `out_valid && !out_ready`, `out_px_vec`, `out_valid` and `out_last` hold stable, and `sel` and `rd_ptr` are frozen.
- Count update per cycle: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full FIFO: `in_ready` = 0 and `in_data` is ignored. A pop in that cycle does not enable a same-cycle push.
- Empty FIFO: no load occurs. `out_valid` drops after its pending vector is consumed.
- Wrap-around: pointers roll from `DEPTH`-1 to 0 with no bubble.
- With `NUM_IN_CHANNELS` = 16: `VPW` = 1, every load pops, `out_last` is always 1, and the block is a pure FIFO.

## Timing
- Reset, when `rst` = 1 at a clock edge:
  - `wr_ptr`, `rd_ptr`, count, `sel` ← 0.
  - `out_valid`, `out_last` ← 0; `out_px_vec` ← 0; `fifo_count` ← 0.
  - `in_ready` = 1 in the cycle after reset.
- Reset mid-operation discards all stored words and any partially consumed word. The first vector after reset comes from the first word pushed after reset, starting at `sel` = 0.
- Latency:
  - A word pushed at edge t into an empty FIFO appears as vector `sel` = 0 with `out_valid` = 1 after edge t+1.
  - `fifo_count` reflects the push after edge t.
- Throughput: one vector per cycle while `out_ready` = 1 and the FIFO is non-empty. Words drain at 1/`VPW` words per cycle.
- No combinational path from `out_ready` to `in_ready`.

## Test plan
- **Single word, N=4.** Push 0x00112233_44556677_8899AABB_CCDDEEFF, hold `out_ready` = 1. Required: four vectors, `out_px_vec[0..3]` = {00,11,22,33}, {44,55,66,77}, {88,99,AA,BB}, {CC,DD,EE,FF}. `out_last` is set only on the fourth. `out_valid` rises one cycle after the push.
- **Backpressure.** Drop `out_ready` for 5 cycles while vector 2 is presented. Required: vector 2 and `out_last` are stable throughout; the sequence resumes with no loss or duplication.
- **Full and wrap, DEPTH=16.** Push 20 words with `out_ready` = 0. Required: `in_ready` falls after the 16th accept and `fifo_count` = 16. Then release `out_ready`. Required: 16 words × 4 vectors emerge in order, including across the pointer wrap.
- **Simultaneous push/pop.** Steady stream with `in_valid` = `out_ready` = 1 and N=16. Required: one word per cycle, `fifo_count` constant, output equal to input delayed by 2 edges.
- **Reset mid-word.** Assert `rst` after vector 1 of a word with 3 words queued. Required: all outputs read 0 the next cycle, `fifo_count` = 0, and the next push emits from `sel` = 0.

Source files
------------

// File: rtl/conv2d_input_unpacker_if.sv
// conv2d_input_unpacker_if
//   Bundles the ingress word stream and the egress pixel-vector stream of the
//   conv2d input unpacker.
//   in_data/in_valid/in_ready          : 128-bit packed word stream (into the unpacker)
//   out_px_vec/out_valid/out_ready     : per-channel pixel vector stream (out of the unpacker)
//   out_last                           : vector is the final slice of its word
//   fifo_count                         : words currently buffered
//   master : environment view (drives words, accepts vectors)
//   slave  : unpacker view
interface conv2d_input_unpacker_if #(
  parameter int DEPTH           = 16,
  parameter int NUM_IN_CHANNELS = 4
);
  logic [127:0]                    in_data;
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_IN_CHANNELS-1:0][7:0] out_px_vec;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;
  logic [$clog2(DEPTH):0]          fifo_count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_px_vec, out_valid, out_last, fifo_count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_px_vec, out_valid, out_last, fifo_count
  );
endinterface

// File: rtl/conv2d_input_unpacker.sv
// conv2d_input_unpacker
//   Buffers 128-bit packed pixel words in a ring-buffer FIFO and unpacks each
//   word into VPW = 16/NUM_IN_CHANNELS consecutive pixel vectors of
//   NUM_IN_CHANNELS bytes. Channel 0 of a vector is taken from the most
//   significant byte of its slice, mirroring the conv2d output packer.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset
//     bus  : conv2d_input_unpacker_if.slave (word in, vector out, fifo_count)
//   DEPTH and NUM_IN_CHANNELS must match the parameters of the connected
//   interface instance.
module conv2d_input_unpacker #(
  parameter int DEPTH           = 16,
  parameter int NUM_IN_CHANNELS = 4
) (
  input logic                    clk,
  input logic                    rst,
  conv2d_input_unpacker_if.slave bus
);

  localparam int VPW   = 16 / NUM_IN_CHANNELS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SEL_W = (VPW > 1) ? $clog2(VPW) : 1;
  localparam int VEC_W = NUM_IN_CHANNELS * 8;

  typedef logic [NUM_IN_CHANNELS-1:0][7:0] vec_t;

  logic [127:0]     fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SEL_W-1:0] sel;

  logic             push;
  logic             load;
  logic             pop;
  logic             sel_last;
  logic             in_ready_c;
  vec_t             slice_p0;

  vec_t             vec_p1;
  logic             vld_p1;
  logic             last_p1;

  // Slice s of a word starts at byte s*N counted from the MSB; shifting the
  // word up by that many bytes lets every channel use a constant part-select.
  function automatic vec_t extract_slice(input logic [127:0] word,
                                         input logic [SEL_W-1:0] s);
    logic [127:0] shifted;
    vec_t         v;
    shifted = word << (int'(s) * VEC_W);
    for (int i = 0; i < NUM_IN_CHANNELS; i++) begin
      v[i] = shifted[127 - i*8 -: 8];
    end
    return v;
  endfunction

  // Stage p0: FIFO head selection and handshake decode
  assign in_ready_c = (count < CNT_W'(DEPTH));
  assign push       = bus.in_valid && in_ready_c;
  assign sel_last   = (sel == SEL_W'(VPW - 1));
  assign load       = (count != '0) && (!vld_p1 || bus.out_ready);
  assign pop        = load && sel_last;
  assign slice_p0   = extract_slice(fifo_mem[rd_ptr], sel);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sel    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (load) begin
        sel <= sel_last ? '0 : sel + SEL_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage p1: registered output vector
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vec_p1  <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      last_p1 <= sel_last;
      vec_p1  <= slice_p0;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_px_vec = vec_p1;
  assign bus.out_valid  = vld_p1;
  assign bus.out_last   = last_p1;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_conv2d_input_unpacker.sv
module tb_conv2d_input_unpacker;
  localparam int DEPTH  = 16;
  localparam int NA     = 4;
  localparam int VPW_A  = 16 / NA;
  localparam int CNT_A  = $clog2(DEPTH) + 1;
  localparam int DEPTH_B = 4;
  localparam int CNT_B  = $clog2(DEPTH_B) + 1;

  typedef logic [NA-1:0][7:0] veca_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv2d_input_unpacker_if #(.DEPTH(DEPTH), .NUM_IN_CHANNELS(NA)) a_if ();
  conv2d_input_unpacker_if #(.DEPTH(DEPTH_B), .NUM_IN_CHANNELS(16)) b_if ();

  conv2d_input_unpacker #(.DEPTH(DEPTH), .NUM_IN_CHANNELS(NA)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  conv2d_input_unpacker #(.DEPTH(DEPTH_B), .NUM_IN_CHANNELS(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  veca_t exp_vec[$];
  bit    exp_last[$];

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Vector s of a word: channel i is byte (s*NA + i) counted from the MSB.
  function automatic veca_t slice_of(input logic [127:0] w, input int s);
    veca_t v;
    for (int i = 0; i < NA; i++) v[i] = 8'(w >> (8 * (15 - (s * NA + i))));
    return v;
  endfunction

  function automatic logic [127:0] byte_rev(input logic [127:0] w);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(w >> (8 * (15 - i)));
    return r;
  endfunction

  task automatic model_push_a(input logic [127:0] w);
    for (int s = 0; s < VPW_A; s++) begin
      exp_vec.push_back(slice_of(w, s));
      exp_last.push_back(s == VPW_A - 1);
    end
  endtask

  task automatic idle_inputs();
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (a_if.out_valid !== 1'b0 || a_if.out_last !== 1'b0 || a_if.out_px_vec !== '0) begin
      n_fail++; $display("FAIL reset_out_a: valid=%b last=%b vec=%h, want 0/0/0", a_if.out_valid, a_if.out_last, a_if.out_px_vec);
    end
    n_checks++;
    if (a_if.fifo_count !== CNT_A'(0)) begin
      n_fail++; $display("FAIL reset_count_a: got %0d want 0", a_if.fifo_count);
    end
    n_checks++;
    if (b_if.out_valid !== 1'b0 || b_if.out_last !== 1'b0 || b_if.out_px_vec !== '0 || b_if.fifo_count !== CNT_B'(0)) begin
      n_fail++; $display("FAIL reset_b: valid=%b last=%b vec=%h count=%0d, want all 0", b_if.out_valid, b_if.out_last, b_if.out_px_vec, b_if.fifo_count);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_if.in_ready !== 1'b1 || b_if.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: a=%b b=%b want 1", a_if.in_ready, b_if.in_ready);
    end
  endtask

  task automatic test_single_word();
    logic [127:0] w;
    veca_t        want [4];
    w = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    want = '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
    @(negedge clk);
    a_if.in_valid = 1'b1; a_if.in_data = w; a_if.out_ready = 1'b1;
    if (a_if.in_valid && a_if.in_ready) model_push_a(w);
    @(negedge clk);
    a_if.in_valid = 1'b0;
    n_checks++;
    if (a_if.out_valid !== 1'b0 || a_if.fifo_count !== CNT_A'(1)) begin
      n_fail++; $display("FAIL single_latency: valid=%b count=%0d, want 0 and 1", a_if.out_valid, a_if.fifo_count);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (a_if.out_valid !== 1'b1 || a_if.out_px_vec !== want[k] || a_if.out_last !== (k == 3)) begin
        n_fail++; $display("FAIL single_vec%0d: valid=%b vec=%h last=%b, want 1 %h %b", k, a_if.out_valid, a_if.out_px_vec, a_if.out_last, want[k], (k == 3));
      end
      if (exp_vec.size() != 0) begin exp_vec.delete(0); exp_last.delete(0); end
    end
    @(negedge clk);
    n_checks++;
    if (a_if.out_valid !== 1'b0 || a_if.fifo_count !== CNT_A'(0)) begin
      n_fail++; $display("FAIL single_drain: valid=%b count=%0d, want 0 and 0", a_if.out_valid, a_if.fifo_count);
    end
  endtask

  task automatic test_backpressure();
    int pushed = 0;
    int consumed = 0;
    int stall = 0;
    bit done = 1'b0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      a_if.in_valid  = (pushed < 2);
      a_if.in_data   = rand128();
      a_if.out_ready = !(consumed == 2 && stall < 5);
      if (!a_if.out_ready) begin
        stall++;
        n_checks++;
        if (a_if.out_valid !== 1'b1) begin
          n_fail++; $display("FAIL bp_stall_valid: got %b want 1", a_if.out_valid);
        end
      end
      if (a_if.in_valid && a_if.in_ready) begin model_push_a(a_if.in_data); pushed++; end
      if (a_if.out_valid) begin
        n_checks++;
        if (exp_vec.size() == 0) begin
          n_fail++; $display("FAIL bp_vec: unexpected vector %h, want none", a_if.out_px_vec);
        end else if (a_if.out_px_vec !== exp_vec[0] || a_if.out_last !== exp_last[0]) begin
          n_fail++; $display("FAIL bp_vec: got %h last=%b, want %h last=%b", a_if.out_px_vec, a_if.out_last, exp_vec[0], exp_last[0]);
        end
        if (a_if.out_ready && exp_vec.size() != 0) begin exp_vec.delete(0); exp_last.delete(0); consumed++; end
      end
      done = (pushed == 2) && (exp_vec.size() == 0) && !a_if.out_valid;
    end
    n_checks++;
    if (!done || consumed != 2 * VPW_A) begin
      n_fail++; $display("FAIL bp_complete: consumed %0d vectors (done=%b), want %0d", consumed, done, 2 * VPW_A);
    end
  endtask

  task automatic test_full_wrap();
    int acc = 0;
    bit done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a_if.in_valid = 1'b1; a_if.in_data = rand128(); a_if.out_ready = 1'b0;
      n_checks++;
      if (a_if.in_ready !== (acc < DEPTH) || a_if.fifo_count !== CNT_A'(acc)) begin
        n_fail++; $display("FAIL full_fill%0d: in_ready=%b count=%0d, want %b %0d", c, a_if.in_ready, a_if.fifo_count, (acc < DEPTH), acc);
      end
      if (a_if.in_valid && a_if.in_ready) begin model_push_a(a_if.in_data); acc++; end
    end
    @(negedge clk);
    a_if.in_valid = 1'b0;
    n_checks++;
    if (a_if.fifo_count !== CNT_A'(DEPTH) || a_if.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_state: count=%0d in_ready=%b, want %0d 0", a_if.fifo_count, a_if.in_ready, DEPTH);
    end
    for (int cyc = 0; cyc < 150 && !done; cyc++) begin
      @(negedge clk);
      a_if.out_ready = 1'b1;
      if (a_if.out_valid) begin
        n_checks++;
        if (exp_vec.size() == 0) begin
          n_fail++; $display("FAIL wrap_vec: unexpected vector %h, want none", a_if.out_px_vec);
        end else if (a_if.out_px_vec !== exp_vec[0] || a_if.out_last !== exp_last[0]) begin
          n_fail++; $display("FAIL wrap_vec: got %h last=%b, want %h last=%b", a_if.out_px_vec, a_if.out_last, exp_vec[0], exp_last[0]);
        end
        if (exp_vec.size() != 0) begin exp_vec.delete(0); exp_last.delete(0); end
      end
      done = (exp_vec.size() == 0) && !a_if.out_valid;
    end
    n_checks++;
    if (!done || a_if.fifo_count !== CNT_A'(0)) begin
      n_fail++; $display("FAIL wrap_drain: done=%b left=%0d count=%0d, want 1 0 0", done, exp_vec.size(), a_if.fifo_count);
    end
  endtask

  task automatic test_stream_n16();
    logic [127:0] hist[$];
    logic [127:0] w;
    for (int k = 0; k <= 42; k++) begin
      @(negedge clk);
      w = rand128();
      b_if.in_valid = (k < 40); b_if.in_data = w; b_if.out_ready = 1'b1;
      if (k < 40) hist.push_back(w);
      if (k >= 1) begin
        n_checks++;
        if (b_if.fifo_count !== CNT_B'((k <= 40) ? 1 : 0) || b_if.in_ready !== 1'b1) begin
          n_fail++; $display("FAIL stream_count%0d: count=%0d in_ready=%b, want %0d 1", k, b_if.fifo_count, b_if.in_ready, (k <= 40) ? 1 : 0);
        end
      end
      if (k >= 2 && k <= 41) begin
        n_checks++;
        if (b_if.out_valid !== 1'b1 || b_if.out_last !== 1'b1 || b_if.out_px_vec !== byte_rev(hist[k-2])) begin
          n_fail++; $display("FAIL stream_out%0d: valid=%b last=%b vec=%h, want 1 1 %h", k, b_if.out_valid, b_if.out_last, b_if.out_px_vec, byte_rev(hist[k-2]));
        end
      end else begin
        n_checks++;
        if (b_if.out_valid !== 1'b0) begin
          n_fail++; $display("FAIL stream_idle%0d: valid=%b want 0", k, b_if.out_valid);
        end
      end
    end
    b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit done = 1'b0;
    int pushed = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_if.in_valid = 1'b1; a_if.in_data = rand128(); a_if.out_ready = 1'b0;
      if (a_if.in_valid && a_if.in_ready) model_push_a(a_if.in_data);
    end
    @(negedge clk);
    a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
    @(negedge clk);
    a_if.out_ready = 1'b0;
    n_checks++;
    if (a_if.out_valid !== 1'b1 || exp_vec.size() < 2 || a_if.out_px_vec !== exp_vec[1]) begin
      n_fail++; $display("FAIL mid_vec1: valid=%b vec=%h, want 1 and second slice of first word", a_if.out_valid, a_if.out_px_vec);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_if.out_valid !== 1'b0 || a_if.out_last !== 1'b0 || a_if.out_px_vec !== '0 || a_if.fifo_count !== CNT_A'(0) || a_if.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: valid=%b last=%b vec=%h count=%0d in_ready=%b, want 0 0 0 0 1", a_if.out_valid, a_if.out_last, a_if.out_px_vec, a_if.fifo_count, a_if.in_ready);
    end
    rst = 1'b0;
    exp_vec.delete(); exp_last.delete();
    @(negedge clk);
    n_checks++;
    if (a_if.out_valid !== 1'b0 || a_if.fifo_count !== CNT_A'(0)) begin
      n_fail++; $display("FAIL mid_idle: valid=%b count=%0d, want 0 0", a_if.out_valid, a_if.fifo_count);
    end
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      a_if.in_valid = (pushed < 1); a_if.in_data = rand128(); a_if.out_ready = 1'b1;
      if (a_if.in_valid && a_if.in_ready) begin model_push_a(a_if.in_data); pushed++; end
      if (a_if.out_valid) begin
        n_checks++;
        if (exp_vec.size() == 0) begin
          n_fail++; $display("FAIL mid_after: unexpected vector %h, want none", a_if.out_px_vec);
        end else if (a_if.out_px_vec !== exp_vec[0] || a_if.out_last !== exp_last[0]) begin
          n_fail++; $display("FAIL mid_after: got %h last=%b, want %h last=%b", a_if.out_px_vec, a_if.out_last, exp_vec[0], exp_last[0]);
        end
        if (exp_vec.size() != 0) begin exp_vec.delete(0); exp_last.delete(0); end
      end
      done = (pushed == 1) && (exp_vec.size() == 0) && !a_if.out_valid;
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL mid_complete: %0d vectors left, want 0", exp_vec.size());
    end
  endtask

  task automatic test_random();
    int  unloaded;
    int  exp_cnt;
    bit  done = 1'b0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge clk);
      a_if.in_valid  = (cyc < 400) && ($urandom_range(0, 1) == 1);
      a_if.in_data   = rand128();
      a_if.out_ready = (cyc >= 400) || ($urandom_range(0, 9) < 7);
      // Words still counted are those with at least one vector not yet in the output register.
      unloaded = exp_vec.size() - (a_if.out_valid ? 1 : 0);
      exp_cnt  = (unloaded + VPW_A - 1) / VPW_A;
      n_checks++;
      if (a_if.fifo_count !== CNT_A'(exp_cnt) || a_if.in_ready !== (exp_cnt < DEPTH)) begin
        n_fail++; $display("FAIL rand_count: count=%0d in_ready=%b, want %0d %b", a_if.fifo_count, a_if.in_ready, exp_cnt, (exp_cnt < DEPTH));
      end
      if (a_if.in_valid && a_if.in_ready) model_push_a(a_if.in_data);
      if (a_if.out_valid) begin
        n_checks++;
        if (exp_vec.size() == 0) begin
          n_fail++; $display("FAIL rand_vec: unexpected vector %h, want none", a_if.out_px_vec);
        end else if (a_if.out_px_vec !== exp_vec[0] || a_if.out_last !== exp_last[0]) begin
          n_fail++; $display("FAIL rand_vec: got %h last=%b, want %h last=%b", a_if.out_px_vec, a_if.out_last, exp_vec[0], exp_last[0]);
        end
        if (a_if.out_ready && exp_vec.size() != 0) begin exp_vec.delete(0); exp_last.delete(0); end
      end
      done = (cyc >= 400) && (exp_vec.size() == 0) && !a_if.out_valid;
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL rand_drain: %0d vectors left, want 0", exp_vec.size());
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_word();
    test_backpressure();
    test_full_wrap();
    test_stream_n16();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
